mac_operand_sequencer: RTL and testbench
========================================

MAC_OPERAND_SEQUENCER -- requirements
Module: mac_operand_sequencer

Interface
REQ-001 Parameter: DATA_WIDTH, 32, IEEE-754 single-precision word width.
REQ-002 Parameter: TAPS, 9, number of pixel/weight pairs per window (3x3 kernel).
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: in_valid  input  1  window and weights present on in_pixels/in_weights.
REQ-006 Port: in_ready  output  1  sequencer can accept a window.
REQ-007 Port: in_pixels  input  TAPS*DATA_WIDTH  window; tap k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 Port: in_weights  input  TAPS*DATA_WIDTH  kernel weights; same packing as in_pixels.
REQ-009 Port: floatA  output  DATA_WIDTH  pixel operand to the downstream multiply-accumulate unit.
REQ-010 Port: floatB  output  DATA_WIDTH  weight operand to the downstream multiply-accumulate unit.
REQ-011 Port: mac_reset  output  1  active-low clear for the downstream accumulator.
REQ-012 Port: acc_result  input  DATA_WIDTH  accumulator value returned by the MAC unit.
REQ-013 Port: out_valid  output  1  out_data holds a finished dot product.
REQ-014 Port: out_ready  input  1  consumer accepts out_data.
REQ-015 Port: out_data  output  DATA_WIDTH  captured dot product.

Function
REQ-016 FSM states SHALL be IDLE, CLEAR, STREAM, CAPTURE, OUT.
REQ-017 IDLE: in_ready=1; in_valid=1 at cycle T latches in_pixels/in_weights internally and moves to CLEAR; in_ready=0 in all other states.
REQ-018 CLEAR (cycle T+1): mac_reset=0 for exactly this cycle; then STREAM with tap counter=0.
REQ-019 STREAM: during cycle T+2+k (k=0..TAPS-1), floatA=pixel k and floatB=weight k; counter wraps from TAPS-1 to CAPTURE, never beyond.
REQ-020 Outside STREAM, floatA and floatB SHALL be 32'h00000000 so the downstream accumulator holds its value.
REQ-021 CAPTURE (cycle T+TAPS+2): acc_result registered into out_data; then OUT.
REQ-022 OUT: out_valid=1, out_data stable until out_valid&&out_ready; handshake returns to IDLE next cycle.
REQ-023 Input-to-out_valid latency SHALL be TAPS+3 cycles (12 for TAPS=9); throughput limit is one window per TAPS+4 cycles minimum.
REQ-024 in_valid while in_ready=0 SHALL be ignored; input buses SHALL NOT be re-sampled mid-window.
REQ-025 out_ready while out_valid=0 SHALL have no effect.
REQ-026 mac_reset SHALL be 1 in all states except CLEAR and while reset=1.

Reset
REQ-027 reset=1 at any clock edge, including mid-STREAM or in OUT, SHALL force IDLE, counter=0, out_valid=0, out_data=0, floatA=floatB=0.
REQ-028 mac_reset SHALL be 0 (combinationally) whenever reset=1 so the accumulator clears with the sequencer.
REQ-029 in_ready SHALL be 1 the first cycle after reset deasserts; a partial window is discarded, never emitted.

Configuration
REQ-030 Macro SEQ_RELU_EN: when defined, CAPTURE stores 32'h00000000 if acc_result[DATA_WIDTH-1]=1, else acc_result.
REQ-031 Without SEQ_RELU_EN, CAPTURE stores acc_result unmodified, including negative values and -0.0.

Verification
REQ-032 All pixels 0x3F800000 (1.0), all weights 0x40000000 (2.0), out_ready=1 -> out_valid at T+12, out_data=0x41900000 (18.0).
REQ-033 Pixels 1.0, weights 0xBF800000 (-1.0) -> out_data=0xC1100000 (-9.0) without SEQ_RELU_EN; 0x00000000 with it.
REQ-034 out_ready held 0 for 5 cycles in OUT -> out_valid and out_data stable, in_ready=0, floatA/floatB=0; accepted on 6th cycle, in_ready=1 next cycle.
REQ-035 reset pulsed at T+5 (mid-STREAM) -> next cycle in_ready=1, out_valid=0, mac_reset=0 during reset; following window of 1.0x2.0 still yields 0x41900000.
REQ-036 Two back-to-back windows (second in_valid held high) -> second accepted the cycle after first out handshake; results independent (accumulator cleared in CLEAR), mac_reset low exactly one cycle per window.

Source files
------------

// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer: streams a latched 3x3 window/weight set into a MAC unit and captures the dot product.
// Optional ReLU on capture: define SEQ_RELU_EN.
module mac_operand_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int TAPS       = 9
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [TAPS*DATA_WIDTH-1:0] in_pixels,
  input  logic [TAPS*DATA_WIDTH-1:0] in_weights,
  output logic [DATA_WIDTH-1:0]      floatA,
  output logic [DATA_WIDTH-1:0]      floatB,
  output logic                       mac_reset,
  input  logic [DATA_WIDTH-1:0]      acc_result,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_data
);
  localparam int CW = (TAPS > 1) ? $clog2(TAPS) : 1;
  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, CAPTURE, OUT} state_e;
  state_e                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [TAPS*DATA_WIDTH-1:0] pix_q, pix_d, wgt_q, wgt_d;
  logic [DATA_WIDTH-1:0]     float_a_q, float_a_d, float_b_q, float_b_d;
  logic [DATA_WIDTH-1:0]     out_data_q, out_data_d, captured;
  logic                      in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic                      mac_reset_q, mac_reset_d, last_tap;
`ifdef SEQ_RELU_EN
  assign captured = acc_result[DATA_WIDTH-1] ? '0 : acc_result;
`else
  assign captured = acc_result;
`endif
  assign last_tap = cnt_q == CW'(TAPS - 1);
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pix_d      = pix_q;
    wgt_d      = wgt_q;
    out_data_d = out_data_q;
    case (state_q)
      IDLE: begin
        state_d = in_valid ? CLEAR : IDLE;
        pix_d   = in_valid ? in_pixels : pix_q;
        wgt_d   = in_valid ? in_weights : wgt_q;
      end
      CLEAR: begin
        state_d = STREAM;
        cnt_d   = '0;
      end
      STREAM: begin
        state_d = last_tap ? CAPTURE : STREAM;
        cnt_d   = last_tap ? '0 : cnt_q + CW'(1);
      end
      CAPTURE: begin
        state_d    = OUT;
        out_data_d = captured;
      end
      OUT:     state_d = out_ready ? IDLE : OUT;
      default: state_d = IDLE;
    endcase
    // Operands are zero outside STREAM so the accumulator holds its value.
    float_a_d   = (state_d == STREAM) ? pix_q[cnt_d*DATA_WIDTH +: DATA_WIDTH] : '0;
    float_b_d   = (state_d == STREAM) ? wgt_q[cnt_d*DATA_WIDTH +: DATA_WIDTH] : '0;
    in_ready_d  = state_d == IDLE;
    out_valid_d = state_d == OUT;
    mac_reset_d = state_d != CLEAR;
  end
  always_ff @(posedge clk) begin
    pix_q <= pix_d;
    wgt_q <= wgt_d;
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      float_a_q   <= '0;
      float_b_q   <= '0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      mac_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      float_a_q   <= float_a_d;
      float_b_q   <= float_b_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      mac_reset_q <= mac_reset_d;
    end
  end
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign floatA    = float_a_q;
  assign floatB    = float_b_q;
  assign mac_reset = mac_reset_q & ~reset;
endmodule

// File: tb/tb_mac_operand_sequencer.sv
// tb_mac_operand_sequencer: randomized windows against an integer-valued float dot-product model and MAC model.
module tb_mac_operand_sequencer;
  localparam int W = 32;
  localparam int N = 9;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [N*W-1:0] in_pixels = '0, in_weights = '0;
  logic in_ready, mac_reset, out_valid;
  logic [W-1:0] floatA, floatB, acc_result, out_data;
  int acc = 0;
  int checks = 0, failures = 0;
  int px[N], wt[N];

  always #5 clk = ~clk;

  mac_operand_sequencer #(.DATA_WIDTH(W), .TAPS(N)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixels(in_pixels), .in_weights(in_weights), .floatA(floatA), .floatB(floatB),
    .mac_reset(mac_reset), .acc_result(acc_result), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data)
  );

  function automatic int f2i(input logic [31:0] f);
    int e, m, v;
    e = int'(f[30:23]);
    if (e == 0) return 0;
    m = 32'h0080_0000 | int'(f[22:0]);
    v = (e >= 150) ? (m <<< (e - 150)) : (m >>> (150 - e));
    return f[31] ? -v : v;
  endfunction

  function automatic logic [31:0] i2f(input int n);
    int a, p;
    a = (n < 0) ? -n : n;
    p = 0;
    if (n == 0) return 32'h0;
    for (int i = 0; i < 31; i++) if (a[i]) p = i;
    return {(n < 0), 8'(127 + p), 23'(a << (23 - p))};
  endfunction

  // Downstream MAC: clears while mac_reset is low, otherwise accumulates the product.
  always @(posedge clk) acc <= !mac_reset ? 0 : acc + f2i(floatA) * f2i(floatB);
  assign acc_result = i2f(acc);

  task automatic scramble();
    for (int k = 0; k < N; k++) begin
      in_pixels[k*W +: W]  = $urandom;
      in_weights[k*W +: W] = $urandom;
    end
  endtask

  task automatic load_random();
    for (int k = 0; k < N; k++) begin
      px[k] = int'($urandom_range(15));
      wt[k] = int'($urandom_range(15)) - 8;
    end
  endtask

  task automatic drive_window(input int hold, input bit keep_valid, input string tag);
    int sum, waited;
    logic [31:0] expd;
    sum = 0;
    waited = 0;
    for (int k = 0; k < N; k++) sum += px[k] * wt[k];
    expd = i2f(sum);
`ifdef SEQ_RELU_EN
    if (sum < 0) expd = 32'h0;
`endif
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s accept in_ready=%b required=1", tag, in_ready);
    end
    in_valid = 1'b1;
    for (int k = 0; k < N; k++) begin
      in_pixels[k*W +: W]  = i2f(px[k]);
      in_weights[k*W +: W] = i2f(wt[k]);
    end
    @(negedge clk);
    in_valid = keep_valid;
    scramble();
    checks++;
    if (mac_reset !== 1'b0 || in_ready !== 1'b0 || floatA !== 32'h0 || floatB !== 32'h0) begin
      failures++;
      $display("FAIL %s clear mac_reset=%b in_ready=%b floatA=%h floatB=%h required 0/0/0/0", tag, mac_reset, in_ready, floatA, floatB);
    end
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      scramble();
      checks++;
      if (floatA !== i2f(px[k]) || floatB !== i2f(wt[k]) || mac_reset !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s stream tap%0d floatA=%h floatB=%h mac_reset=%b out_valid=%b in_ready=%b required %h %h 1 0 0",
                 tag, k, floatA, floatB, mac_reset, out_valid, in_ready, i2f(px[k]), i2f(wt[k]));
      end
    end
    @(negedge clk);
    checks++;
    if (floatA !== 32'h0 || floatB !== 32'h0 || out_valid !== 1'b0 || mac_reset !== 1'b1) begin
      failures++;
      $display("FAIL %s capture floatA=%h floatB=%h out_valid=%b mac_reset=%b required 0 0 0 1", tag, floatA, floatB, out_valid, mac_reset);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== expd) begin
      failures++;
      $display("FAIL %s result out_valid=%b out_data=%h required 1 %h", tag, out_valid, out_data, expd);
    end
    out_ready = (hold == 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== expd || in_ready !== 1'b0 || floatA !== 32'h0 || floatB !== 32'h0 || mac_reset !== 1'b1) begin
        failures++;
        $display("FAIL %s hold%0d out_valid=%b out_data=%h in_ready=%b floatA=%h floatB=%h mac_reset=%b required 1 %h 0 0 0 1",
                 tag, i, out_valid, out_data, in_ready, floatA, floatB, mac_reset, expd);
      end
      out_ready = (i == hold - 1);
    end
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s release in_ready=%b out_valid=%b required 1 0", tag, in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (mac_reset !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'h0 || floatA !== 32'h0 || floatB !== 32'h0) begin
      failures++;
      $display("FAIL reset_state mac_reset=%b out_valid=%b out_data=%h floatA=%h floatB=%h required all 0", mac_reset, out_valid, out_data, floatA, floatB);
    end
    reset = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || mac_reset !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release in_ready=%b mac_reset=%b out_valid=%b required 1 1 0", in_ready, mac_reset, out_valid);
    end
  endtask

  task automatic test_fixed();
    for (int k = 0; k < N; k++) begin px[k] = 1; wt[k] = 2; end
    drive_window(0, 1'b0, "ones_x_twos");
    for (int k = 0; k < N; k++) wt[k] = -1;
    drive_window(0, 1'b0, "ones_x_neg");
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      load_random();
      drive_window(int'($urandom_range(3)), 1'b0, "random");
    end
  endtask

  task automatic test_backpressure();
    load_random();
    drive_window(5, 1'b0, "backpressure");
  endtask

  task automatic test_mid_reset();
    load_random();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midreset_accept in_ready=%b required=1", in_ready);
    end
    in_valid = 1'b1;
    for (int k = 0; k < N; k++) begin
      in_pixels[k*W +: W]  = i2f(px[k]);
      in_weights[k*W +: W] = i2f(wt[k]);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (mac_reset !== 1'b0) begin
      failures++;
      $display("FAIL midreset_macreset mac_reset=%b required=0", mac_reset);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || floatA !== 32'h0 || mac_reset !== 1'b1) begin
      failures++;
      $display("FAIL midreset_after in_ready=%b out_valid=%b floatA=%h mac_reset=%b required 1 0 0 1", in_ready, out_valid, floatA, mac_reset);
    end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL midreset_idle%0d out_valid=%b in_ready=%b required 0 1", i, out_valid, in_ready);
      end
    end
    for (int k = 0; k < N; k++) begin px[k] = 1; wt[k] = 2; end
    drive_window(0, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    load_random();
    drive_window(2, 1'b1, "b2b_first");
    load_random();
    drive_window(0, 1'b0, "b2b_second");
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_random();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
